// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types for the HI/LO multiply/divide unit.
package mips_pkg;

   // Opcodes for the HI/LO unit; encodings 6 and 7 are accepted and dropped.
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   // Control states of the iterative unit.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/div_iter.sv
// One restoring-divide step on unsigned magnitudes: shift the next dividend
// bit into the partial remainder, subtract the divisor if it fits, and shift
// the resulting quotient bit into the low end of the quotient register.
module div_iter #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_in,
   input  logic [DATA_W-1:0] quo_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_out,
   output logic [DATA_W-1:0] quo_out
);

   logic [DATA_W:0] shifted;
   logic            fits;

   // Trial subtraction. The partial remainder is always below the divisor,
   // so the difference fits in DATA_W bits whenever the subtraction succeeds.
   always_comb begin
      shifted = {rem_in, quo_in[DATA_W-1]};
      fits    = (shifted >= {1'b0, divisor});
      rem_out = fits ? (shifted[DATA_W-1:0] - divisor) : shifted[DATA_W-1:0];
      quo_out = {quo_in[DATA_W-2:0], fits};
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO unit: iterative MULT/MULTU/DIV/DIVU on magnitudes with a
// final sign fix-up, single-cycle MTHI/MTLO, and the architectural HI/LO.
module muldiv_unit
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   // Two's-complement negate of one word when neg is set.
   function automatic logic [DATA_W-1:0] fix_word(input logic [DATA_W-1:0] v,
                                                  input logic              neg);
      return neg ? -v : v;
   endfunction

   // Two's-complement negate of a double-width product when neg is set.
   function automatic logic [2*DATA_W-1:0] fix_dword(input logic [2*DATA_W-1:0] v,
                                                     input logic                neg);
      return neg ? -v : v;
   endfunction

   md_op_t              op_e;
   md_state_t           state, state_nxt;
   logic [CNT_W-1:0]    cnt;

   // Iteration registers: upper/lower form the 2*DATA_W accumulator for a
   // multiply, and the partial remainder / quotient pair for a divide.
   logic [DATA_W-1:0]   upper, lower, opnd;
   logic                is_div, neg_q, neg_r;

   logic                accept, start_md, last_step, signed_op, op_is_div, s1, s2;
   logic [DATA_W-1:0]   mag1, mag2;
   logic [DATA_W:0]     add_sum;
   logic [DATA_W-1:0]   mul_up_n, mul_lo_n, div_up_n, div_lo_n, up_n, lo_n;
   logic [DATA_W-1:0]   hi_res, lo_res;
   logic [2*DATA_W-1:0] prod_fix;

   assign op_e      = md_op_t'(op);
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   // A flush in IDLE swallows the request presented in the same cycle.
   assign accept    = in_valid && in_ready && !flush;
   assign op_is_div = (op_e == MD_DIV) || (op_e == MD_DIVU);
   assign start_md  = accept && ((op_e == MD_MULT) || (op_e == MD_MULTU) || op_is_div);
   assign signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
   assign s1        = signed_op && in1[DATA_W-1];
   assign s2        = signed_op && in2[DATA_W-1];
   assign mag1      = fix_word(in1, s1);
   assign mag2      = fix_word(in2, s2);
   assign last_step = (state == RUN) && (cnt == CNT_LAST);

   div_iter #(.DATA_W(DATA_W)) u_div_iter (
      .rem_in  (upper),
      .quo_in  (lower),
      .divisor (opnd),
      .rem_out (div_up_n),
      .quo_out (div_lo_n)
   );

   // Shift-add multiply step, operand select, and sign fix-up of the final result.
   always_comb begin
      add_sum  = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
      mul_up_n = add_sum[DATA_W:1];
      mul_lo_n = {add_sum[0], lower[DATA_W-1:1]};
      up_n     = is_div ? div_up_n : mul_up_n;
      lo_n     = is_div ? div_lo_n : mul_lo_n;
      prod_fix = fix_dword({up_n, lo_n}, neg_q);
      hi_res   = is_div ? fix_word(up_n, neg_r) : prod_fix[2*DATA_W-1:DATA_W];
      lo_res   = is_div ? fix_word(lo_n, neg_q) : prod_fix[DATA_W-1:0];
   end

   // Next-state logic; flush abandons an op before its results commit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_md) state_nxt = RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand latch at accept, then one iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (start_md) begin
         upper  <= '0;
         lower  <= op_is_div ? mag1 : mag2;
         opnd   <= op_is_div ? mag2 : mag1;
         is_div <= op_is_div;
         neg_q  <= s1 ^ s2;
         neg_r  <= s1;
      end else if (state == RUN) begin
         upper  <= up_n;
         lower  <= lo_n;
      end
   end

   // State, iteration counter and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         if (start_md)
            cnt <= '0;
         else if (state == RUN)
            cnt <= cnt + CNT_W'(1);
         if (accept && (op_e == MD_MTHI))
            hi <= in1;
         if (accept && (op_e == MD_MTLO))
            lo <= in1;
         if (last_step && !flush) begin
            hi <= hi_res;
            lo <= lo_res;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, hand-written
// reset/flush/MTHI/MTLO sequences, and random ops against an arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, in_valid, flush;
   logic [2:0]    op;
   logic [W-1:0]  in1, in2;
   logic          in_ready, busy, done;
   logic [W-1:0]  hi, lo;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0] exp_hi, exp_lo;

   typedef struct {
      string      nm;
      logic [2:0] op;
      logic [31:0] a, b, hi, lo;
   } vec_t;

   vec_t tbl [11];

   muldiv_unit #(.DATA_W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .in1      (in1),
      .in2      (in2),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Reference results straight from MIPS arithmetic rules.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
      logic signed [63:0] sa, sb, sp, q, r;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      h = 32'h0;
      l = 32'h0;
      case (o)
         3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
         3'd1: begin up = {32'h0, a} * {32'h0, b}; h = up[63:32]; l = up[31:0]; end
         3'd2: begin
            if (b == 32'h0) begin
               h = a;
               l = a[31] ? 32'h1 : 32'hFFFF_FFFF;
            end else begin
               q = sa / sb;
               r = sa % sb;
               h = r[31:0];
               l = q[31:0];
            end
         end
         3'd3: begin
            if (b == 32'h0) begin
               h = a;
               l = 32'hFFFF_FFFF;
            end else begin
               h = a % b;
               l = a / b;
            end
         end
         default: ;
      endcase
   endfunction

   // Issue one mult/div, wait for done, and check latency, busy and the done pulse.
   task automatic run_md(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int cyc;
      bit bad;
      op = o; in1 = a; in2 = b; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      op  = 3'($urandom_range(0, 7));
      in1 = $urandom;
      in2 = $urandom;
      cyc = 0;
      bad = 1'b0;
      while (!done && cyc < 100) begin
         if (!busy || in_ready) bad = 1'b1;
         tick;
         cyc++;
      end
      if (!busy || in_ready) bad = 1'b1;
      check({nm, " latency"}, 64'(cyc), 64'd32);
      check({nm, " busy"}, 64'(bad), 64'd0);
      check({nm, " hi"}, 64'(hi), 64'(exp_hi));
      check({nm, " lo"}, 64'(lo), 64'(exp_lo));
      tick;
      check({nm, " done pulse"}, {62'd0, done, in_ready}, 64'd1);
   endtask

   initial begin
      int dcnt;
      logic [31:0] a, b;
      logic [2:0]  o;

      tbl[0]  = '{"multu_max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[1]  = '{"mult_m2x3",   3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      tbl[2]  = '{"mult_min2",   3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
      tbl[3]  = '{"div_m7_2",    3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[4]  = '{"divu_7_2",    3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
      tbl[5]  = '{"div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      tbl[6]  = '{"div_m5_0",    3'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0001};
      tbl[7]  = '{"divu_9_0",    3'd3, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF};
      tbl[8]  = '{"div_5_0",     3'd2, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
      tbl[9]  = '{"div_7_m2",    3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      tbl[10] = '{"mult_max_m1", 3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

      reset = 1'b1; in_valid = 1'b0; flush = 1'b0; op = 3'd0; in1 = '0; in2 = '0;
      tick;
      tick;
      check("reset busy", 64'(busy), 64'd0);
      check("reset ready", 64'(in_ready), 64'd1);
      check("reset done", 64'(done), 64'd0);
      check("reset hilo", {hi, lo}, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         exp_hi = tbl[i].hi;
         exp_lo = tbl[i].lo;
         run_md(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b);
      end

      // Reset in the middle of a MULT.
      op = 3'd0; in1 = 32'd3; in2 = 32'd5; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (9) tick;
      check("midrun busy", 64'(busy), 64'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midrun reset busy", 64'(busy), 64'd0);
      check("midrun reset ready", 64'(in_ready), 64'd1);
      check("midrun reset hilo", {hi, lo}, 64'd0);

      // MTHI then MTLO back to back.
      op = 3'd4; in1 = 32'h1234; in_valid = 1'b1;
      tick;
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi nodone", {62'd0, done, busy}, 64'd0);
      op = 3'd5; in1 = 32'h5678;
      tick;
      in_valid = 1'b0;
      check("mtlo hilo", {hi, lo}, 64'h0000_1234_0000_5678);
      check("mtlo nodone", {62'd0, done, busy}, 64'd0);

      // DIV accepted then flushed; a request during RUN is ignored.
      op = 3'd2; in1 = 32'd100; in2 = 32'd7; in_valid = 1'b1;
      tick;
      op = 3'd4; in1 = 32'hDEAD;
      tick;
      check("run ready", 64'(in_ready), 64'd0);
      check("run ignores mthi", 64'(hi), 64'h1234);
      in_valid = 1'b0;
      tick;
      tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      check("flush idle", {62'd0, busy, in_ready}, 64'd1);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dcnt++;
         tick;
      end
      check("flush nodone", 64'(dcnt), 64'd0);
      check("flush hilo", {hi, lo}, 64'h0000_1234_0000_5678);

      // Flush in IDLE blocks a same-cycle MTLO.
      op = 3'd5; in1 = 32'h9999; in_valid = 1'b1; flush = 1'b1;
      tick;
      in_valid = 1'b0; flush = 1'b0;
      check("idle flush blocks mtlo", 64'(lo), 64'h5678);

      exp_hi = 32'h1234;
      exp_lo = 32'h5678;

      // Random ops against the model.
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 6))
            0: b = 32'h0;
            1: a = 32'h8000_0000;
            2: b = 32'hFFFF_FFFF;
            3: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         if (o <= 3'd3) begin
            model(o, a, b, exp_hi, exp_lo);
            run_md($sformatf("rand%0d op%0d", i, o), o, a, b);
         end else begin
            if (o == 3'd4) exp_hi = a;
            if (o == 3'd5) exp_lo = a;
            op = o; in1 = a; in2 = b; in_valid = 1'b1;
            tick;
            in_valid = 1'b0;
            check($sformatf("rand%0d op%0d hilo", i, o), {hi, lo}, {exp_hi, exp_lo});
            check($sformatf("rand%0d op%0d idle", i, o), {62'd0, busy, done}, 64'd0);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
